writeback_cycle: RTL

// Final pipeline stage. Consumes the register-write controls emitted by decode (rf_write_enable/addr/data_sel)

---
 rtl/writeback_cycle.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/writeback_cycle.sv
// Final pipeline stage: selects and formats the instruction result and drives the register-file
// write port. Loads wait in StWaitMem for the memory response while upstream is back-pressured.
module writeback_cycle #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned REGISTER_SIZE = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     rf_write_enable,
    input  logic [REGISTER_SIZE-1:0] rf_write_addr,
    input  logic [1:0]               rf_write_data_sel,
    input  logic [XLEN-1:0]          alu_result,
    input  logic [XLEN-1:0]          pc_in,
    input  logic                     dm_read_enable,
    input  logic [2:0]               dm_load_type,
    input  logic [1:0]               dm_byte_offset,
    input  logic                     dm_rvalid,
    input  logic [XLEN-1:0]          dm_read_data,
    output logic                     rf_writeback_enable,
    output logic [REGISTER_SIZE-1:0] rf_writeback_addr,
    output logic [XLEN-1:0]          rf_writeback_data
);

    typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

    state_e                   state_q, state_d;
    logic                     cap_write_q, cap_write_d;
    logic [REGISTER_SIZE-1:0] cap_addr_q, cap_addr_d;
    logic [1:0]               cap_sel_q, cap_sel_d;
    logic [XLEN-1:0]          cap_alu_q, cap_alu_d;
    logic [XLEN-1:0]          cap_pc_q, cap_pc_d;
    logic [2:0]               cap_lt_q, cap_lt_d;
    logic [1:0]               cap_off_q, cap_off_d;
    logic                     wb_en_q, wb_en_d;
    logic [REGISTER_SIZE-1:0] wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]          wb_data_q, wb_data_d;
    logic                     accept;

    function automatic logic writes_rd(logic we, logic [REGISTER_SIZE-1:0] addr, logic [1:0] sel,
                                       logic is_load);
        // Load-data select without an actual load has nothing to write.
        return we && (addr != '0) && (sel != 2'b11) && !((sel == 2'b01) && !is_load);
    endfunction

    function automatic logic [XLEN-1:0] format_load(logic [2:0] lt, logic [1:0] off,
                                                    logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (lt)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] select_result(logic [1:0] sel, logic [XLEN-1:0] alu,
                                                      logic [XLEN-1:0] pc, logic [XLEN-1:0] load);
        case (sel)
            2'b01:   return load;
            2'b10:   return pc + XLEN'(4);
            default: return alu;
        endcase
    endfunction

    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cap_write_q <= 1'b0;
            cap_addr_q  <= '0;
            cap_sel_q   <= '0;
            cap_alu_q   <= '0;
            cap_pc_q    <= '0;
            cap_lt_q    <= '0;
            cap_off_q   <= '0;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cap_write_q <= cap_write_d;
            cap_addr_q  <= cap_addr_d;
            cap_sel_q   <= cap_sel_d;
            cap_alu_q   <= cap_alu_d;
            cap_pc_q    <= cap_pc_d;
            cap_lt_q    <= cap_lt_d;
            cap_off_q   <= cap_off_d;
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept && dm_read_enable) state_d = StWaitMem;
            StWaitMem: if (dm_rvalid) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        cap_write_d = cap_write_q;
        cap_addr_d  = cap_addr_q;
        cap_sel_d   = cap_sel_q;
        cap_alu_d   = cap_alu_q;
        cap_pc_d    = cap_pc_q;
        cap_lt_d    = cap_lt_q;
        cap_off_d   = cap_off_q;
        wb_en_d     = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        if (accept && dm_read_enable) begin
            cap_write_d = writes_rd(rf_write_enable, rf_write_addr, rf_write_data_sel, 1'b1);
            cap_addr_d  = rf_write_addr;
            cap_sel_d   = rf_write_data_sel;
            cap_alu_d   = alu_result;
            cap_pc_d    = pc_in;
            cap_lt_d    = dm_load_type;
            cap_off_d   = dm_byte_offset;
        end else if (accept && writes_rd(rf_write_enable, rf_write_addr, rf_write_data_sel, 1'b0)) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rf_write_addr;
            wb_data_d = select_result(rf_write_data_sel, alu_result, pc_in, '0);
        end else if ((state_q == StWaitMem) && dm_rvalid && cap_write_q) begin
            wb_en_d   = 1'b1;
            wb_addr_d = cap_addr_q;
            wb_data_d = select_result(cap_sel_q, cap_alu_q, cap_pc_q,
                                      format_load(cap_lt_q, cap_off_q, dm_read_data));
        end
    end

    assign rf_writeback_enable = wb_en_q;
    assign rf_writeback_addr   = wb_addr_q;
    assign rf_writeback_data   = wb_data_q;

endmodule
